sim_end_ctrl: RTL

- Simulation-only completion controller downstream of the per-tile test nodes. Each node contains DMA test nodes and AXI bandwidth monitors.
- Collects every node's end-of-simulation flag and every bandwidth monitor's AR/AW in-flight counts.
- Waits until all traffic has drained for a programmable quiet window, then signals global completion.
- A watchdog flags hung simulations instead.

---
 rtl/sim_end_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sim_end_ctrl.sv
// End-of-simulation controller: collects node completion flags, waits for a quiet drain
// window, then flags done (or timeout). Optional macro SIM_END_CTRL_STOP_EN adds $stop/$fatal.
module sim_end_ctrl #(
  parameter int unsigned NumNodes      = 16,
  parameter int unsigned NumMonitors   = 32,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned DrainCycles   = 1000,
  parameter int unsigned TimeoutCycles = 10000000,
  parameter int unsigned CycleWidth    = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            en_i,
  input  logic [NumNodes-1:0]             end_of_sim_i,
  input  logic [NumMonitors*CntWidth-1:0] ar_in_flight_i,
  input  logic [NumMonitors*CntWidth-1:0] aw_in_flight_i,
  output logic [$clog2(NumNodes+1)-1:0]   pending_o,
  output logic                            draining_o,
  output logic                            done_o,
  output logic                            timeout_o,
  output logic [CycleWidth-1:0]           finish_cycle_o
);

  localparam int unsigned PendW  = $clog2(NumNodes + 1);
  localparam int unsigned QuietW = (DrainCycles > 0) ? $clog2(DrainCycles + 1) : 1;
  localparam logic [QuietW-1:0]     QuietLast   = QuietW'((DrainCycles > 0) ? DrainCycles - 1 : 0);
  localparam logic [CycleWidth-1:0] TimeoutLast = CycleWidth'(TimeoutCycles - 1);
  localparam logic [CycleWidth-1:0] CycleMax    = '1;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_DRAIN,
    ST_DONE,
    ST_TIMEOUT
  } state_e;

  state_e                  state_q, state_d;
  logic [NumNodes-1:0]     eos_q, eos_d;
  logic [CycleWidth-1:0]   cycle_q, cycle_d;
  logic [QuietW-1:0]       quiet_q, quiet_d;
  logic [PendW-1:0]        pending_q, pending_d;
  logic [CycleWidth-1:0]   finish_q, finish_d;
  logic                    quiet;

  function automatic logic [PendW-1:0] count_pending(input logic [NumNodes-1:0] eos);
    logic [PendW-1:0] n;
    n = PendW'(NumNodes);
    for (int i = 0; i < NumNodes; i++) n = n - PendW'(eos[i]);
    return n;
  endfunction

  // NOTE: every signal gets a default before any branch so no latch can be inferred.
  always_comb begin
    state_d  = state_q;
    eos_d    = eos_q;
    cycle_d  = cycle_q;
    quiet_d  = quiet_q;
    finish_d = finish_q;
    quiet    = ~(|ar_in_flight_i) & ~(|aw_in_flight_i);

    if (en_i) begin
      eos_d = eos_q | end_of_sim_i;
      if (cycle_q != CycleMax) cycle_d = cycle_q + 1'b1;

      unique case (state_q)
        ST_WAIT: begin
          if (&eos_q) begin
            if (DrainCycles == 0) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_DRAIN;
              quiet_d = '0;
            end
          end
        end
        ST_DRAIN: begin
          if (quiet) begin
            quiet_d = quiet_q + 1'b1;
            if (quiet_q == QuietLast) state_d = ST_DONE;
          end else begin
            quiet_d = '0;
          end
        end
        default: ;
      endcase

      // Clean completion takes priority when it lands on the watchdog cycle.
      if ((state_q == ST_WAIT || state_q == ST_DRAIN) && state_d != ST_DONE &&
          cycle_q == TimeoutLast) begin
        state_d = ST_TIMEOUT;
      end

      if (state_d != state_q && (state_d == ST_DONE || state_d == ST_TIMEOUT)) begin
        finish_d = cycle_q + 1'b1;
      end
    end

    pending_d = count_pending(eos_d);
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q   <= ST_WAIT;
      eos_q     <= '0;
      cycle_q   <= '0;
      quiet_q   <= '0;
      pending_q <= PendW'(NumNodes);
      finish_q  <= '0;
    end else begin
      state_q   <= state_d;
      eos_q     <= eos_d;
      cycle_q   <= cycle_d;
      quiet_q   <= quiet_d;
      pending_q <= pending_d;
      finish_q  <= finish_d;
    end
  end

  assign pending_o      = pending_q;
  assign draining_o     = (state_q == ST_DRAIN);
  assign done_o         = (state_q == ST_DONE);
  assign timeout_o      = (state_q == ST_TIMEOUT);
  assign finish_cycle_o = finish_q;

`ifdef SIM_END_CTRL_STOP_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i && en_i && state_d != state_q) begin
      if (state_d == ST_DONE) begin
        $display("-- End Simulation -- finish_cycle=%0d", finish_d);
        $stop;
      end else if (state_d == ST_TIMEOUT) begin
        $write("-- Simulation Timeout -- pending=%0d unfinished:", pending_d);
        for (int i = 0; i < NumNodes; i++) begin
          if (!eos_d[i]) $write(" %0d", i);
        end
        $write("\n");
        $fatal(1, "sim_end_ctrl watchdog expired");
      end
    end
  end
`else
  // Without the macro the environment watches done_o / timeout_o itself.
`endif

endmodule
